router_local_in_port: RTL
=========================

// Module: router_local_in_port
// PURPOSE
//  Router-side receiver for the NIC injection link: the far end of the NIC's out_link_o/is_valid_o
//  and credit_signal_i/free_signal_i. Buffers incoming flits in one FIFO per virtual channel and
//  forwards them to the router's switch stage over a valid/ready port, with round-robin arbitration
//  that holds the grant for a whole packet. Returns one credit per popped flit and one free pulse
//  per popped tail flit, so the NIC's credit counters and VC allocation stay consistent.
// PARAMETERS
//  FLIT_WIDTH    64  flit width in bits; must match the NIC flit width
//  N_TOT_OF_VC   4   total VCs (N_OF_VC*N_OF_VN), one FIFO each
//  VC_DEPTH      4   flits per VC FIFO; equals the NIC MAX_CREDIT
//  N_BITS_VC_ID  2   clog2(N_TOT_OF_VC)
// PORTS
//  clk              in   1                clock
//  rst              in   1                reset, asynchronous, active-low
//  in_link_i        in   FLIT_WIDTH       flit from the NIC
//  is_valid_i       in   1                in_link_i holds a flit this cycle
//  credit_signal_o  out  N_TOT_OF_VC      one-cycle pulse per VC: one flit slot freed
//  free_signal_o    out  N_TOT_OF_VC      one-cycle pulse per VC: tail popped, VC reallocatable
//  flit_o           out  FLIT_WIDTH       flit presented to the switch stage
//  flit_vc_o        out  N_BITS_VC_ID     VC that flit_o comes from
//  flit_valid_o     out  1                flit_o is valid
//  flit_ready_i     in   1                switch stage accepts flit_o; pop when valid & ready
//  ovf_err_o        out  1                sticky: a flit arrived at a full VC
// BEHAVIOUR
//  Flit fields: type = in_link_i[FLIT_WIDTH-1 -: 2] (00 head, 01 body, 10 tail, 11 head-tail);
//  VC id = in_link_i[FLIT_WIDTH-3 -: N_BITS_VC_ID]. The block passes flits through unmodified.
//  Reset (rst=0, async): all FIFOs empty, credit_signal_o=0, free_signal_o=0, flit_valid_o=0,
//  ovf_err_o=0, grant unlocked, rr_ptr=N_TOT_OF_VC-1 (VC0 has first priority).
//  Reset mid-packet discards all buffered flits; no credits are returned for them.
//  Push: a flit is written into FIFO[vc] at the rising edge where is_valid_i=1.
//  Push to a full FIFO: the flit is dropped and ovf_err_o is set, even if the same VC pops in that
//  cycle. ovf_err_o clears only on reset.
//  A flit is visible at flit_o no earlier than the cycle after its push; there is no bypass.
//  Per-VC occupancy counter runs 0..VC_DEPTH. Pointers wrap modulo VC_DEPTH.
//  Simultaneous push and pop on a non-full VC leaves the count unchanged.
//  Arbiter state: UNLOCKED or LOCKED(lock_vc).
//   UNLOCKED: select the first non-empty VC scanning rr_ptr+1, rr_ptr+2, ... (mod N_TOT_OF_VC).
//     flit_valid_o=1 if any VC is non-empty. Popping a head flit -> LOCKED(selected VC).
//     Popping a head-tail flit -> stay UNLOCKED and set rr_ptr=selected VC.
//   LOCKED(v): flit_vc_o=v and flit_valid_o=!empty[v]. Other VCs are never selected, even if v is
//     empty. Popping a tail -> UNLOCKED, rr_ptr=v.
//  flit_o, flit_vc_o and flit_valid_o are combinational from FIFO and arbiter state.
//  flit_o/flit_vc_o are don't-care when flit_valid_o=0.
//  Holding flit_ready_i=0 keeps flit_o stable.
//  Credit: a pop from VC v at edge t gives credit_signal_o[v]=1 during cycle t+1 (registered).
//  At most one credit bit is high per cycle.
//  Free: popping a tail or head-tail flit also gives free_signal_o[v]=1 in the same cycle as
//  that credit.
// TESTING
//  1) Reset, then one head-tail flit on VC2 -> flit_valid_o=1 with flit_vc_o=2 one cycle later;
//     with ready=1, credit_signal_o=4'b0100 and free_signal_o=4'b0100 for exactly one cycle.
//  2) 5-flit packet (H,B,B,B,T) on VC1, ready=0 -> first 4 flits are stored; the 5th (tail) is
//     dropped and ovf_err_o=1; then ready=1 -> 4 pops, 4 credits on bit1, no free pulse.
//  3) Head on VC0 popped, then head-tail on VC3 pushed while VC0 is empty -> flit_valid_o=0
//     (locked on VC0) until VC0's tail arrives and is popped; VC3 is served on the next cycle.
//  4) Head-tail flits waiting on VC0..VC3, ready=1 -> pop order 0,1,2,3; refill all four ->
//     pop order 0,1,2,3 again (rr_ptr=3 after the last pop).
//  5) VC1 holds 3 flits; push and pop VC1 in the same cycle -> count stays 3; credit bit1 pulses
//     the next cycle; ovf_err_o=0.
//  6) Assert rst with 2 flits buffered on VC2 -> outputs clear immediately without a clock edge;
//     no credit pulse follows the release of reset.

Source files
------------

// File: rtl/router_local_in_port_if.sv
// Link bundle between the NIC-side injection channel and the router switch stage.
// The router input port uses the slave view; the driving environment uses master.
interface router_local_in_port_if #(
   parameter int FLIT_WIDTH   = 64,
   parameter int N_TOT_OF_VC  = 4,
   parameter int N_BITS_VC_ID = 2
);
   logic [FLIT_WIDTH-1:0]   in_link_i;
   logic                    is_valid_i;
   logic [N_TOT_OF_VC-1:0]  credit_signal_o;
   logic [N_TOT_OF_VC-1:0]  free_signal_o;
   logic [FLIT_WIDTH-1:0]   flit_o;
   logic [N_BITS_VC_ID-1:0] flit_vc_o;
   logic                    flit_valid_o;
   logic                    flit_ready_i;
   logic                    ovf_err_o;

   modport slave (
      input  in_link_i, is_valid_i, flit_ready_i,
      output credit_signal_o, free_signal_o, flit_o, flit_vc_o, flit_valid_o, ovf_err_o
   );

   modport master (
      output in_link_i, is_valid_i, flit_ready_i,
      input  credit_signal_o, free_signal_o, flit_o, flit_vc_o, flit_valid_o, ovf_err_o
   );
endinterface

// File: rtl/router_local_in_port.sv
// Router local input port: one FIFO per VC, packet-holding round-robin arbiter,
// registered credit/free return toward the NIC.
module router_local_in_port_vc_fifo #(
   parameter int FLIT_WIDTH = 64,
   parameter int VC_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [FLIT_WIDTH-1:0] wdata,
   output logic [FLIT_WIDTH-1:0] rdata,
   output logic                  empty,
   output logic                  full
);
   localparam int PW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
   localparam int CW = $clog2(VC_DEPTH + 1);

   logic [FLIT_WIDTH-1:0] mem [VC_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         cnt;
   logic                  wr_en, rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full FIFO is dropped even when the same VC pops this cycle.
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(VC_DEPTH));
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end
endmodule

module router_local_in_port #(
   parameter int FLIT_WIDTH   = 64,
   parameter int N_TOT_OF_VC  = 4,
   parameter int VC_DEPTH     = 4,
   parameter int N_BITS_VC_ID = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   router_local_in_port_if.slave lnk
);
   localparam logic [1:0] HEAD      = 2'b00;
   localparam logic [1:0] TAIL      = 2'b10;
   localparam logic [1:0] HEAD_TAIL = 2'b11;

   typedef enum logic {UNLOCKED, LOCKED} arb_state_e;

   arb_state_e                             state, state_nxt;
   logic [N_BITS_VC_ID-1:0]                lock_vc, lock_vc_nxt;
   logic [N_BITS_VC_ID-1:0]                rr_ptr, rr_ptr_nxt;
   logic [N_BITS_VC_ID-1:0]                in_vc, sel_vc, rr_sel;
   logic [N_TOT_OF_VC-1:0]                 push, pop, empty, full;
   logic [N_TOT_OF_VC-1:0][FLIT_WIDTH-1:0] rdata;
   logic [N_TOT_OF_VC-1:0]                 credit_q, free_q;
   logic                                   ovf_q;
   logic                                   flit_valid, pop_fire, rr_found;
   logic [1:0]                             pop_type;

   assign in_vc = lnk.in_link_i[FLIT_WIDTH-3 -: N_BITS_VC_ID];

   for (genvar g = 0; g < N_TOT_OF_VC; g++) begin : g_vc
      assign push[g] = lnk.is_valid_i && (in_vc == N_BITS_VC_ID'(g));
      assign pop[g]  = pop_fire && (sel_vc == N_BITS_VC_ID'(g));

      router_local_in_port_vc_fifo #(
         .FLIT_WIDTH (FLIT_WIDTH),
         .VC_DEPTH   (VC_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .pop   (pop[g]),
         .wdata (lnk.in_link_i),
         .rdata (rdata[g]),
         .empty (empty[g]),
         .full  (full[g])
      );
   end

   // Arbiter state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= UNLOCKED;
         lock_vc <= '0;
         rr_ptr  <= N_BITS_VC_ID'(N_TOT_OF_VC - 1);
      end else begin
         state   <= state_nxt;
         lock_vc <= lock_vc_nxt;
         rr_ptr  <= rr_ptr_nxt;
      end
   end

   // Arbiter next state: heads lock, tails unlock, head-tails only move the pointer
   always_comb begin
      state_nxt   = state;
      lock_vc_nxt = lock_vc;
      rr_ptr_nxt  = rr_ptr;
      if (pop_fire) begin
         case (state)
            UNLOCKED: begin
               if (pop_type == HEAD) begin
                  state_nxt   = LOCKED;
                  lock_vc_nxt = sel_vc;
               end else if (pop_type == HEAD_TAIL) begin
                  rr_ptr_nxt = sel_vc;
               end
            end
            LOCKED: begin
               if (pop_type == TAIL) begin
                  state_nxt  = UNLOCKED;
                  rr_ptr_nxt = lock_vc;
               end
            end
            default: state_nxt = UNLOCKED;
         endcase
      end
   end

   // Arbiter outputs: a locked VC is served exclusively, even while it is empty
   always_comb begin
      rr_sel   = rr_ptr;
      rr_found = 1'b0;
      for (int k = 1; k <= N_TOT_OF_VC; k++) begin
         if (!rr_found && !empty[(int'(rr_ptr) + k) % N_TOT_OF_VC]) begin
            rr_found = 1'b1;
            rr_sel   = N_BITS_VC_ID'((int'(rr_ptr) + k) % N_TOT_OF_VC);
         end
      end
      if (state == LOCKED) begin
         sel_vc     = lock_vc;
         flit_valid = !empty[lock_vc];
      end else begin
         sel_vc     = rr_sel;
         flit_valid = rr_found;
      end
   end

   assign pop_fire = flit_valid && lnk.flit_ready_i;
   assign pop_type = rdata[sel_vc][FLIT_WIDTH-1 -: 2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q <= '0;
         free_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         credit_q <= pop;
         free_q   <= pop_type[1] ? pop : '0;
         ovf_q    <= ovf_q | (lnk.is_valid_i && full[in_vc]);
      end
   end

   assign lnk.flit_o          = rdata[sel_vc];
   assign lnk.flit_vc_o       = sel_vc;
   assign lnk.flit_valid_o    = flit_valid;
   assign lnk.credit_signal_o = credit_q;
   assign lnk.free_signal_o   = free_q;
   assign lnk.ovf_err_o       = ovf_q;
endmodule
